// File: rtl/fp8_pkg.sv
// Shared FP8 E4M3 format constants and the unpack stream state type.
package fp8_pkg;
    localparam int E4M3_BIAS       = 7;
    localparam int FP32_BIAS       = 127;
    localparam int E4M3_EXP_W      = 4;
    localparam int E4M3_MAN_W      = 3;
    localparam int E4M3_EXP_OFFSET = FP32_BIAS - E4M3_BIAS;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;
endpackage

// File: rtl/fp8_e4m3_to_fp32.sv
// Exact combinational widening of one FP8 E4M3 value (no NaN/Inf encodings) to IEEE-754 FP32.
module fp8_e4m3_to_fp32
    import fp8_pkg::*;
(
    input  logic [7:0]  i_e4m3,
    output logic [31:0] o_fp32
);
    logic                  w_sign;
    logic [E4M3_EXP_W-1:0] w_exp;
    logic [E4M3_MAN_W-1:0] w_man;

    assign w_sign = i_e4m3[7];
    assign w_exp  = i_e4m3[6:3];
    assign w_man  = i_e4m3[2:0];

    // Subnormals are renormalised on the leading one of the fraction; every E4M3 value fits FP32 exactly.
    always_comb begin
        o_fp32 = {w_sign, 31'b0};
        if (w_exp != '0)
            o_fp32 = {w_sign, 8'(E4M3_EXP_OFFSET) + {{(8 - E4M3_EXP_W){1'b0}}, w_exp}, w_man, 20'b0};
        else if (w_man[2])
            o_fp32 = {w_sign, 8'(E4M3_EXP_OFFSET), w_man[1:0], 21'b0};
        else if (w_man[1])
            o_fp32 = {w_sign, 8'(E4M3_EXP_OFFSET - 1), w_man[0], 22'b0};
        else if (w_man[0])
            o_fp32 = {w_sign, 8'(E4M3_EXP_OFFSET - 2), 23'b0};
    end
endmodule

// File: rtl/fp8_e4m3_unpack_dequant.sv
// Unpacks masked words of packed E4M3 lanes into a stream of FP32 values, one per cycle.
module fp8_e4m3_unpack_dequant
    import fp8_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int CNT_W  = 16,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [LANES-1:0]     in_mask,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [LANE_W-1:0]    out_lane,
    output logic                 out_last,
    output logic                 err_empty_last,
    output logic [CNT_W-1:0]     out_cnt
);
    state_t               r_state;
    logic [8*LANES-1:0]   r_data;
    logic [LANES-1:0]     r_mask;
    logic                 r_last;
    logic [31:0]          r_outData;
    logic [LANE_W-1:0]    r_outLane;
    logic                 r_outLast;
    logic                 r_err;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_fire;
    logic                 w_accept;
    logic                 w_finalLane;
    logic [LANES-1:0]     w_remNext;
    logic                 w_load;
    logic [LANES-1:0]     w_srcMask;
    logic [8*LANES-1:0]   w_srcData;
    logic                 w_srcLast;
    logic [LANE_W-1:0]    w_srcLane;
    logic [7:0]           w_srcByte;
    logic                 w_srcOneHot;
    logic [31:0]          w_srcFp32;

    assign out_valid      = (r_state == EMIT);
    assign out_data       = r_outData;
    assign out_lane       = r_outLane;
    assign out_last       = r_outLast;
    assign err_empty_last = r_err;
    assign out_cnt        = r_cnt;

    assign w_fire      = out_valid && out_ready;
    assign w_remNext   = r_mask & (r_mask - LANES'(1));
    assign w_finalLane = (w_remNext == '0);
    assign in_ready    = (r_state == IDLE) || (w_fire && w_finalLane);
    assign w_accept    = in_valid && in_ready;

    // Output registers preload from the new word on accept, or from the held word after a non-final handshake.
    always_comb begin
        w_load    = 1'b0;
        w_srcMask = in_mask;
        w_srcData = in_data;
        w_srcLast = in_last;
        if (w_accept && (in_mask != '0)) begin
            w_load = 1'b1;
        end else if (w_fire && !w_finalLane) begin
            w_load    = 1'b1;
            w_srcMask = w_remNext;
            w_srcData = r_data;
            w_srcLast = r_last;
        end
    end

    always_comb begin
        w_srcLane = '0;
        w_srcByte = w_srcData[7:0];
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_srcMask[i]) begin
                w_srcLane = LANE_W'(i);
                w_srcByte = w_srcData[i*8 +: 8];
            end
        end
    end

    assign w_srcOneHot = ((w_srcMask & (w_srcMask - LANES'(1))) == '0);

    fp8_e4m3_to_fp32 u_conv (
        .i_e4m3 (w_srcByte),
        .o_fp32 (w_srcFp32)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_mask    <= '0;
            r_last    <= 1'b0;
            r_outData <= '0;
            r_outLane <= '0;
            r_outLast <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_err <= w_accept && (in_mask == '0) && in_last;
            if (w_fire)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_accept && (in_mask != '0)) begin
                r_state <= EMIT;
                r_data  <= in_data;
                r_mask  <= in_mask;
                r_last  <= in_last;
            end else if (w_accept || (w_fire && w_finalLane)) begin
                r_state   <= IDLE;
                r_mask    <= '0;
                r_outLast <= 1'b0;
            end else if (w_fire) begin
                r_mask <= w_remNext;
            end
            if (w_load) begin
                r_outData <= w_srcFp32;
                r_outLane <= w_srcLane;
                r_outLast <= w_srcLast && w_srcOneHot;
            end
        end
    end
endmodule

// File: tb/tb_fp8_e4m3_unpack_dequant.sv
// Self-checking bench: constant vector table, full encoding sweep, handshake corners and random traffic.
module tb_fp8_e4m3_unpack_dequant;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_mask;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;
    logic        err_empty_last;
    logic [15:0] out_cnt;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  lane;
        logic        last;
    } exp_t;

    typedef struct {
        logic [31:0]      data;
        logic [3:0]       mask;
        logic             last;
        logic [3:0][31:0] expv;
    } vec_t;

    exp_t        expQ[$];
    exp_t        monExp;
    int          fireCycQ[$];
    vec_t        vecs[5];
    int          nVec = 0;
    int          nFail = 0;
    int          expCnt = 0;
    int          cyc = 0;
    bit          randReady = 1'b0;
    logic        acceptOutValid;
    logic [1:0]  acceptOutLane;

    fp8_e4m3_unpack_dequant #(.LANES(4), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_mask        (in_mask),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_lane       (out_lane),
        .out_last       (out_last),
        .err_empty_last (err_empty_last),
        .out_cnt        (out_cnt)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Value-level reference: evaluate the E4M3 number as a real, then repack the exact double as FP32.
    function automatic logic [31:0] refFp32(input logic [7:0] b);
        real         mag;
        int          ex;
        int          e;
        int          f;
        logic [63:0] d;
        e = int'(b[6:3]);
        f = int'(b[2:0]);
        if (e == 0) begin
            mag = real'(f);
            ex  = -9;
        end else begin
            mag = real'(8 + f);
            ex  = e - 10;
        end
        if (mag == 0.0) return {b[7], 31'b0};
        while (ex > 0) begin mag = mag * 2.0; ex--; end
        while (ex < 0) begin mag = mag / 2.0; ex++; end
        d = $realtobits(mag);
        return {b[7], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nVec++;
        if (act !== req) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic pushWord(input logic [31:0] data, input logic [3:0] mask, input logic last);
        int hi = -1;
        for (int i = 0; i < 4; i++) if (mask[i]) hi = i;
        for (int i = 0; i < 4; i++)
            if (mask[i]) expQ.push_back('{data: refFp32(data[i*8 +: 8]), lane: 2'(i), last: last && (i == hi)});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] mask, input logic last, input bit autoExp);
        int waitCyc = 0;
        bit done = 1'b0;
        in_data  = data;
        in_mask  = mask;
        in_last  = last;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done           = 1'b1;
                acceptOutValid = out_valid;
                acceptOutLane  = out_lane;
                if (autoExp) pushWord(data, mask, last);
            end
            nextCycle();
            waitCyc++;
            if (!done && waitCyc > 1000) begin
                nVec++;
                nFail++;
                $display("[TB] FAIL accept_timeout: got no in_ready, expected accept within 1000 cycles");
                break;
            end
        end
        in_valid = 1'b0;
        if (done) checkOutput("err_empty_last", 32'(err_empty_last), 32'((mask == 4'b0) && last));
    endtask

    task automatic drain();
        int c = 0;
        while (expQ.size() != 0 && c < 500) begin
            nextCycle();
            c++;
        end
        checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
    endtask

    // Scoreboard: every output handshake must match the next expected element in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            expCnt = 0;
        end else if (out_valid && out_ready) begin
            fireCycQ.push_back(cyc);
            expCnt++;
            nVec++;
            if (expQ.size() == 0) begin
                nFail++;
                $display("[TB] FAIL unexpected_output: got data=%h lane=%0d, expected no output", out_data, out_lane);
            end else begin
                monExp = expQ.pop_front();
                if (out_data !== monExp.data || out_lane !== monExp.lane || out_last !== monExp.last) begin
                    nFail++;
                    $display("[TB] FAIL output: got data=%h lane=%0d last=%b, expected data=%h lane=%0d last=%b",
                             out_data, out_lane, out_last, monExp.data, monExp.lane, monExp.last);
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 1.5ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          c0;
        int          hi;
        int          need;
        logic [31:0] w;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{data: 32'hC001_0338, mask: 4'hF, last: 1'b1,
                    expv: {32'hC000_0000, 32'h3B00_0000, 32'h3BC0_0000, 32'h3F80_0000}};
        vecs[1] = '{data: 32'h0080_FF7F, mask: 4'hF, last: 1'b0,
                    expv: {32'h0000_0000, 32'h8000_0000, 32'hC3F0_0000, 32'h43F0_0000}};
        vecs[2] = '{data: 32'h4011_3811, mask: 4'b1010, last: 1'b1,
                    expv: {32'h4000_0000, 32'h0, 32'h3F80_0000, 32'h0}};
        vecs[3] = '{data: 32'h8707_0402, mask: 4'hF, last: 1'b1,
                    expv: {32'hBC60_0000, 32'h3C60_0000, 32'h3C00_0000, 32'h3B80_0000}};
        vecs[4] = '{data: 32'h084F_F801, mask: 4'b0101, last: 1'b1,
                    expv: {32'h0, 32'h40F0_0000, 32'h0, 32'h3B00_0000}};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready",  32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data",  out_data, 32'd0);
        checkOutput("reset_out_lane",  32'(out_lane), 32'd0);
        checkOutput("reset_out_last",  32'(out_last), 32'd0);
        checkOutput("reset_err",       32'(err_empty_last), 32'd0);
        checkOutput("reset_out_cnt",   32'(out_cnt), 32'd0);
        rst_n = 1'b1;
        nextCycle();

        // Constant vectors with hand-derived FP32 results.
        for (int v = 0; v < 5; v++) begin
            c0 = expCnt;
            hi = -1;
            for (int i = 0; i < 4; i++) if (vecs[v].mask[i]) hi = i;
            for (int i = 0; i < 4; i++)
                if (vecs[v].mask[i])
                    expQ.push_back('{data: vecs[v].expv[i], lane: 2'(i), last: vecs[v].last && (i == hi)});
            applyStimulus(vecs[v].data, vecs[v].mask, vecs[v].last, 1'b0);
            if (v == 0) checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
            drain();
            checkOutput("table_out_cnt", 32'(out_cnt), 32'(16'(c0 + $countones(vecs[v].mask))));
        end

        for (int k = 0; k < 64; k++) begin
            w = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
            applyStimulus(w, 4'hF, 1'(k), 1'b1);
        end
        drain();

        fireCycQ.delete();
        applyStimulus($urandom, 4'hF, 1'b0, 1'b1);
        applyStimulus($urandom, 4'hF, 1'b1, 1'b1);
        checkOutput("b2b_accept_valid", 32'(acceptOutValid), 32'd1);
        checkOutput("b2b_accept_lane",  32'(acceptOutLane), 32'd3);
        drain();
        checkOutput("b2b_count", 32'(fireCycQ.size()), 32'd8);
        checkOutput("b2b_span",  32'(fireCycQ[7] - fireCycQ[0]), 32'd7);

        w = $urandom;
        applyStimulus(w, 4'hF, 1'b1, 1'b1);
        nextCycle();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_out_data",  out_data, refFp32(w[15:8]));
            checkOutput("stall_out_lane",  32'(out_lane), 32'd1);
            checkOutput("stall_in_ready",  32'(in_ready), 32'd0);
            nextCycle();
        end
        out_ready = 1'b1;
        drain();

        applyStimulus($urandom, 4'b0000, 1'b1, 1'b1);
        checkOutput("empty_no_valid", 32'(out_valid), 32'd0);
        nextCycle();
        checkOutput("err_pulse_width", 32'(err_empty_last), 32'd0);
        applyStimulus($urandom, 4'b0000, 1'b0, 1'b1);
        nextCycle();
        checkOutput("empty_nolast_valid", 32'(out_valid), 32'd0);
        checkOutput("empty_nolast_err",   32'(err_empty_last), 32'd0);
        checkOutput("pre_reset_out_cnt",  32'(out_cnt), 32'(16'(expCnt)));

        // Asynchronous reset between edges after lane 1 has retired.
        applyStimulus($urandom, 4'hF, 1'b1, 1'b1);
        nextCycle();
        nextCycle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_out_cnt",   32'(out_cnt), 32'd0);
        checkOutput("async_in_ready",  32'(in_ready), 32'd1);
        expQ.delete();
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        applyStimulus($urandom, 4'hF, 1'b1, 1'b1);
        drain();
        checkOutput("cnt_after_reset", 32'(out_cnt), 32'd4);

        randReady = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 4) == 0) nextCycle();
            applyStimulus($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();
        randReady = 1'b0;
        out_ready = 1'b1;
        checkOutput("random_out_cnt", 32'(out_cnt), 32'(16'(expCnt)));

        need = 65535 - expCnt;
        while (need >= 4) begin
            applyStimulus($urandom, 4'hF, 1'b0, 1'b1);
            need -= 4;
        end
        if (need > 0) applyStimulus($urandom, 4'((1 << need) - 1), 1'b0, 1'b1);
        drain();
        checkOutput("cnt_preload", 32'(out_cnt), 32'h0000_FFFF);
        applyStimulus($urandom, 4'b0001, 1'b1, 1'b1);
        drain();
        checkOutput("cnt_wrap", 32'(out_cnt), 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
